// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic phase controller: FSM state codes and
// the default timing constants used as parameter defaults.
package traffic_pkg;

    typedef enum logic [1:0] {
        ST_GREEN  = 2'd0,
        ST_YELLOW = 2'd1,
        ST_ALLRED = 2'd2
    } tl_state_e;

    localparam int DEF_N_PHASES    = 4;
    localparam int DEF_T_MIN_GREEN = 4;
    localparam int DEF_T_MAX_GREEN = 10;
    localparam int DEF_T_YELLOW    = 2;
    localparam int DEF_T_ALL_RED   = 1;
    localparam int DEF_CNT_W       = 8;

endpackage

// File: rtl/phase_timer.sv
// Per-state cycle counter: cleared on a state change, holds while frozen,
// otherwise counts up and saturates at all-ones.
module phase_timer
    import traffic_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             freeze,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (!freeze && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Traffic signal phase controller: serves one phase at a time through
// GREEN -> YELLOW -> ALLRED, with round-robin demand service and ambulance preemption.
module traffic_phase_ctrl
    import traffic_pkg::*;
#(
    parameter int N_PHASES    = DEF_N_PHASES,
    parameter int T_MIN_GREEN = DEF_T_MIN_GREEN,
    parameter int T_MAX_GREEN = DEF_T_MAX_GREEN,
    parameter int T_YELLOW    = DEF_T_YELLOW,
    parameter int T_ALL_RED   = DEF_T_ALL_RED,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic                        Clk,
    input  logic                        reset,
    input  logic [N_PHASES-1:0]         req,
    input  logic [N_PHASES-1:0]         amb,
    output logic [N_PHASES-1:0]         red,
    output logic [N_PHASES-1:0]         yellow,
    output logic [N_PHASES-1:0]         green,
    output logic [$clog2(N_PHASES)-1:0] phase,
    output logic [1:0]                  state
);

    localparam int PW = $clog2(N_PHASES);

    // Timer value on the final cycle of each timed interval.
    localparam logic [CNT_W-1:0] MIN_LAST = CNT_W'(T_MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] MAX_LAST = CNT_W'(T_MAX_GREEN - 1);
    localparam logic [CNT_W-1:0] YEL_LAST = CNT_W'(T_YELLOW - 1);
    localparam logic [CNT_W-1:0] AR_LAST  = CNT_W'(T_ALL_RED - 1);
    localparam logic [N_PHASES-1:0] ONE_HOT0 = N_PHASES'(1);

    tl_state_e           st, st_nxt;
    logic [PW-1:0]       phase_q, phase_nxt;
    logic [PW-1:0]       target_q, target_nxt;
    logic [CNT_W-1:0]    timer;
    logic                timer_clr, timer_frz;

    logic                rr_found;
    logic [PW-1:0]       rr_idx;
    logic [PW-1:0]       rr_cand;
    logic                amb_any;
    logic [PW-1:0]       amb_idx;

    logic [N_PHASES-1:0] red_n, yellow_n, green_n;

    phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk    (Clk),
        .reset  (reset),
        .clear  (timer_clr),
        .freeze (timer_frz),
        .count  (timer)
    );

    // Next phase with demand, searching upward from the one after the current phase.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        rr_cand  = '0;
        for (int i = 1; i < N_PHASES; i++) begin
            rr_cand = PW'((int'(phase_q) + i) % N_PHASES);
            if (!rr_found && req[rr_cand]) begin
                rr_found = 1'b1;
                rr_idx   = rr_cand;
            end
        end
    end

    always_comb begin
        amb_any = |amb;
        amb_idx = '0;
        for (int i = N_PHASES - 1; i >= 0; i--) begin
            if (amb[i]) amb_idx = PW'(i);
        end
    end

    always_comb begin
        st_nxt     = st;
        phase_nxt  = phase_q;
        target_nxt = target_q;
        timer_frz  = 1'b0;
        case (st)
            ST_GREEN: begin
                // An ambulance on the served phase pins the green and its timer.
                if (amb[phase_q]) begin
                    timer_frz = 1'b1;
                end else if (amb_any) begin
                    st_nxt     = ST_YELLOW;
                    target_nxt = amb_idx;
                end else if (rr_found &&
                             (((timer >= MIN_LAST) && !req[phase_q]) || (timer >= MAX_LAST))) begin
                    st_nxt     = ST_YELLOW;
                    target_nxt = rr_idx;
                end
            end
            ST_YELLOW: begin
                if (amb_any) target_nxt = amb_idx;
                if (timer >= YEL_LAST) st_nxt = ST_ALLRED;
            end
            ST_ALLRED: begin
                if (amb_any) target_nxt = amb_idx;
                if (timer >= AR_LAST) begin
                    st_nxt    = ST_GREEN;
                    phase_nxt = target_nxt;
                end
            end
            default: st_nxt = ST_GREEN;
        endcase
    end

    assign timer_clr = (st_nxt != st);

    always_comb begin
        red_n    = '1;
        yellow_n = '0;
        green_n  = '0;
        case (st_nxt)
            ST_GREEN: begin
                green_n[phase_nxt] = 1'b1;
                red_n[phase_nxt]   = 1'b0;
            end
            ST_YELLOW: begin
                yellow_n[phase_nxt] = 1'b1;
                red_n[phase_nxt]    = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!reset) begin
            st       <= ST_GREEN;
            phase_q  <= '0;
            target_q <= '0;
            red      <= ~ONE_HOT0;
            yellow   <= '0;
            green    <= ONE_HOT0;
        end else begin
            st       <= st_nxt;
            phase_q  <= phase_nxt;
            target_q <= target_nxt;
            red      <= red_n;
            yellow   <= yellow_n;
            green    <= green_n;
        end
    end

    assign phase = phase_q;
    assign state = st;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Bench for traffic_phase_ctrl: directed scenarios plus random demand/preemption,
// checked against a cycles-served reference model through an expected queue.
module tb_traffic_phase_ctrl;

    localparam int NP    = 4;
    localparam int T_MIN = 4;
    localparam int T_MAX = 10;
    localparam int T_YEL = 2;
    localparam int T_AR  = 1;

    // clock / reset
    logic       clk = 1'b0;
    logic       reset_i = 1'b0;
    logic [3:0] req_i = '0;
    logic [3:0] amb_i = '0;
    logic [3:0] red_o, yellow_o, green_o;
    logic [1:0] phase_o, state_o;

    always #5 clk = ~clk;

    traffic_phase_ctrl dut (
        .Clk    (clk),
        .reset  (reset_i),
        .req    (req_i),
        .amb    (amb_i),
        .red    (red_o),
        .yellow (yellow_o),
        .green  (green_o),
        .phase  (phase_o),
        .state  (state_o)
    );

    logic [15:0] exp_q[$];
    logic [15:0] mon_e;
    int n_vec = 0;
    int n_bad = 0;

    // reference model: stage 0/1/2 = green/yellow/all-red, m_served counts
    // the cycles the current stage has been shown, starting at 1
    int m_phase, m_stage, m_served, m_target;

    task automatic model_step(input logic r, input logic [3:0] q, input logic [3:0] a);
        int win, pick;
        logic [3:0] rl, yl, gl;
        if (!r) begin
            m_phase = 0; m_stage = 0; m_served = 1; m_target = 0;
        end else begin
            win = -1;
            for (int i = NP - 1; i >= 0; i--) if (a[i]) win = i;
            if (m_stage == 0) begin
                if (!a[m_phase]) begin
                    pick = -1;
                    for (int k = 1; k < NP; k++)
                        if (pick < 0 && q[(m_phase + k) % NP]) pick = (m_phase + k) % NP;
                    if (win >= 0) begin
                        m_stage = 1; m_served = 1; m_target = win;
                    end else if (pick >= 0 &&
                                 ((m_served >= T_MIN && !q[m_phase]) || m_served >= T_MAX)) begin
                        m_stage = 1; m_served = 1; m_target = pick;
                    end else begin
                        m_served++;
                    end
                end
            end else if (m_stage == 1) begin
                if (win >= 0) m_target = win;
                if (m_served >= T_YEL) begin m_stage = 2; m_served = 1; end
                else m_served++;
            end else begin
                if (win >= 0) m_target = win;
                if (m_served >= T_AR) begin
                    m_stage = 0; m_served = 1; m_phase = m_target;
                end else m_served++;
            end
        end
        rl = 4'b1111; yl = 4'b0000; gl = 4'b0000;
        if (m_stage == 0) begin gl[m_phase] = 1'b1; rl[m_phase] = 1'b0; end
        if (m_stage == 1) begin yl[m_phase] = 1'b1; rl[m_phase] = 1'b0; end
        exp_q.push_back({rl, yl, gl, 2'(m_phase), 2'(m_stage)});
    endtask

    // driver tasks
    task automatic cyc(input logic r, input logic [3:0] q, input logic [3:0] a);
        @(negedge clk);
        reset_i = r; req_i = q; amb_i = a;
        model_step(r, q, a);
    endtask

    task automatic expect_now(input string name, input logic [3:0] g, input logic [3:0] y,
                              input logic [3:0] r, input logic [1:0] ph, input logic [1:0] st);
        @(posedge clk); #1;
        n_vec++;
        if ({green_o, yellow_o, red_o, phase_o, state_o} !== {g, y, r, ph, st}) begin
            n_bad++;
            $display("FAIL %s t=%0t: got g=%b y=%b r=%b ph=%0d st=%0d, want g=%b y=%b r=%b ph=%0d st=%0d",
                     name, $time, green_o, yellow_o, red_o, phase_o, state_o, g, y, r, ph, st);
        end
    endtask

    function automatic bit lamps_ok(input logic [3:0] r, input logic [3:0] y, input logic [3:0] g);
        int lit;
        lit = 0;
        for (int i = 0; i < NP; i++) begin
            if ((32'(r[i]) + 32'(y[i]) + 32'(g[i])) != 1) return 1'b0;
            if (!r[i]) lit++;
        end
        return lit <= 1;
    endfunction

    // scoreboard monitor
    initial begin
        forever begin
            @(posedge clk); #1;
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                n_vec++;
                if ({red_o, yellow_o, green_o, phase_o, state_o} !== mon_e) begin
                    n_bad++;
                    $display("FAIL scoreboard t=%0t: got r=%b y=%b g=%b ph=%0d st=%0d, want r=%b y=%b g=%b ph=%0d st=%0d",
                             $time, red_o, yellow_o, green_o, phase_o, state_o,
                             mon_e[15:12], mon_e[11:8], mon_e[7:4], mon_e[3:2], mon_e[1:0]);
                end
                n_vec++;
                if (!lamps_ok(red_o, yellow_o, green_o)) begin
                    n_bad++;
                    $display("FAIL lamp_exclusive t=%0t: got r=%b y=%b g=%b, want one lamp per phase and <=1 non-red",
                             $time, red_o, yellow_o, green_o);
                end
            end
        end
    end

    // stimulus
    initial begin
        int len, cycles;
        logic [3:0] q, a;
        logic r;

        // reset state
        cyc(0, 4'b0000, 4'b0000);
        cyc(0, 4'b0000, 4'b0000);
        expect_now("reset_state", 4'b0001, 4'b0000, 4'b1110, 2'd0, 2'd0);

        // no demand: green holds
        for (int i = 0; i < 50; i++) begin
            cyc(1, 4'b0000, 4'b0000);
            expect_now("idle_hold", 4'b0001, 4'b0000, 4'b1110, 2'd0, 2'd0);
        end

        // max-out from phase 0 to phase 2
        cyc(0, 4'b0000, 4'b0000);
        for (int i = 1; i <= 13; i++) begin
            cyc(1, 4'b0101, 4'b0000);
            if (i <= 9)       expect_now("maxout_green",  4'b0001, 4'b0000, 4'b1110, 2'd0, 2'd0);
            else if (i <= 11) expect_now("maxout_yellow", 4'b0000, 4'b0001, 4'b1110, 2'd0, 2'd1);
            else if (i == 12) expect_now("maxout_allred", 4'b0000, 4'b0000, 4'b1111, 2'd0, 2'd2);
            else              expect_now("maxout_next",   4'b0100, 4'b0000, 4'b1011, 2'd2, 2'd0);
        end

        // round-robin from phase 1 picks phase 3 before phase 0
        cyc(0, 4'b0000, 4'b0000);
        repeat (6) cyc(1, 4'b0010, 4'b0000);
        cyc(1, 4'b0010, 4'b0000);
        expect_now("rr_phase1", 4'b0010, 4'b0000, 4'b1101, 2'd1, 2'd0);
        repeat (4) cyc(1, 4'b0010, 4'b0000);
        repeat (3) cyc(1, 4'b1001, 4'b0000);
        cyc(1, 4'b1001, 4'b0000);
        expect_now("rr_wrap", 4'b1000, 4'b0000, 4'b0111, 2'd3, 2'd0);

        // preemption to phase 2, then hold under competing demand
        cyc(0, 4'b0000, 4'b0000);
        cyc(1, 4'b0000, 4'b0000);
        cyc(1, 4'b0000, 4'b0100);
        expect_now("preempt_yellow", 4'b0000, 4'b0001, 4'b1110, 2'd0, 2'd1);
        repeat (2) cyc(1, 4'b0000, 4'b0100);
        cyc(1, 4'b0000, 4'b0100);
        expect_now("preempt_green", 4'b0100, 4'b0000, 4'b1011, 2'd2, 2'd0);
        for (int i = 0; i < 30; i++) begin
            cyc(1, 4'b1011, 4'b0100);
            expect_now("preempt_hold", 4'b0100, 4'b0000, 4'b1011, 2'd2, 2'd0);
        end

        // reset during the second yellow cycle
        repeat (4) cyc(1, 4'b1011, 4'b0000);
        cyc(1, 4'b1011, 4'b0000);
        expect_now("yellow2", 4'b0000, 4'b0100, 4'b1011, 2'd2, 2'd1);
        cyc(0, 4'b1011, 4'b0000);
        expect_now("reset_mid_yellow", 4'b0001, 4'b0000, 4'b1110, 2'd0, 2'd0);

        // random demand, preemption and occasional reset
        cycles = 0;
        while (cycles < 2500) begin
            len = $urandom_range(1, 12);
            q   = 4'($urandom_range(0, 15));
            a   = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
            r   = ($urandom_range(0, 49) != 0);
            for (int k = 0; k < len; k++) begin
                cyc((k == 0) ? r : 1'b1, q, a);
                cycles++;
            end
        end
        cyc(1, 4'b0000, 4'b0000);

        @(negedge clk);
        @(negedge clk);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        end

        // final report
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/traffic_phase_ctrl.md
TRAFFIC_PHASE_CTRL -- requirements
Module: traffic_phase_ctrl

Interface
REQ-001 SHALL have parameter N_PHASES, default 4, number of signal groups (2..8).
REQ-002 SHALL have parameter T_MIN_GREEN, default 4, minimum green cycles.
REQ-003 SHALL have parameter T_MAX_GREEN, default 10, maximum green cycles under competing demand (>= T_MIN_GREEN).
REQ-004 SHALL have parameter T_YELLOW, default 2, yellow cycles (>= 1).
REQ-005 SHALL have parameter T_ALL_RED, default 1, all-red clearance cycles (>= 1).
REQ-006 SHALL have parameter CNT_W, default 8, timer width; every T_* value SHALL fit in CNT_W bits.
REQ-007 SHALL have port Clk, input, 1, the only clock; all logic is on its rising edge.
REQ-008 SHALL have port reset, input, 1, synchronous and active-low.
REQ-009 SHALL have port req, input, N_PHASES, per-phase vehicle sensor, level.
REQ-010 SHALL have port amb, input, N_PHASES, per-phase ambulance preemption, level.
REQ-011 SHALL have ports red, yellow, green, output, N_PHASES each, registered lamp drives.
REQ-012 SHALL have port phase, output, $clog2(N_PHASES), index of the phase currently served.
REQ-013 SHALL have port state, output, 2, current FSM state code.

Function
REQ-014 The FSM SHALL have the states GREEN=0, YELLOW=1, ALLRED=2.
REQ-015 Lamps: in GREEN, green[phase]=1; in YELLOW, yellow[phase]=1; all other lamps red. In ALLRED, every red=1.
REQ-016 Exactly one of red/yellow/green SHALL be 1 per phase in every cycle, and at most one phase SHALL be non-red.
REQ-017 The timer SHALL be 0 on the first cycle of each state, increment each cycle, and saturate at 2^CNT_W-1.
REQ-018 GREEN->YELLOW on gap-out: timer>=T_MIN_GREEN-1, req[phase]=0, and any other req bit set.
REQ-019 GREEN->YELLOW on max-out: timer>=T_MAX_GREEN-1 and any other req bit set.
REQ-020 With no other req bit set, GREEN SHALL hold indefinitely.
REQ-021 On GREEN->YELLOW, target SHALL be the first set req bit searching round-robin from phase+1, wrapping modulo N_PHASES.
REQ-022 YELLOW SHALL last exactly T_YELLOW cycles and then go to ALLRED.
REQ-023 ALLRED SHALL last exactly T_ALL_RED cycles and then go to GREEN with phase<=target.
REQ-024 Preemption: the lowest-index set amb bit wins.
REQ-025 In GREEN, a winning amb index different from phase SHALL force YELLOW on the next cycle, ignoring T_MIN_GREEN, with target = that index.
REQ-026 In YELLOW or ALLRED, a set amb SHALL overwrite target each cycle; state timing is unchanged. Target may equal phase.
REQ-027 While amb[phase]=1 in GREEN, the timer SHALL freeze and no transition SHALL occur, even if other req or amb bits are set.
REQ-028 All state changes SHALL appear on the outputs one cycle after the deciding inputs are sampled.

Reset
REQ-029 When reset=0 at a rising Clk edge: state=GREEN, phase=0, target=0, timer=0, green=1 on phase 0 only, red=1 on all other phases, yellow=0.
REQ-030 Reset SHALL take effect from any state, including mid-YELLOW or mid-ALLRED, and SHALL discard any pending target.

Structure
REQ-031 Package traffic_pkg SHALL hold the state enum and the default T_* constants.
REQ-032 The counter SHALL be a sub-module phase_timer (CNT_W, clear, freeze, count out).
REQ-033 The round-robin and lowest-index priority selects SHALL be combinational in the top module.

Verification (N_PHASES=4, defaults)
REQ-034 Hold reset=0 for 2 cycles -> green=0001, red=1110, yellow=0000, phase=0, state=0.
REQ-035 Drive req=0000 for 50 cycles -> green stays 0001 throughout.
REQ-036 Drive req=0101 from cycle 0 -> 10 green cycles, then yellow=0001 for 2 cycles, then red=1111 for 1 cycle, then green=0100.
REQ-037 Phase 1 green, timer>=3, drive req=1001 -> next green is phase 3, not phase 0.
REQ-038 Drive amb=0100 at phase-0 timer=1 -> yellow next cycle, green=0100 after 3 more cycles; hold amb 30 cycles with req=1011 -> green stays 0100.
REQ-039 Drive reset=0 during the second YELLOW cycle -> next cycle green=0001 and state=0.
